// File: rtl/max_pool_2x2_if.sv
// Pixel stream in, pooled stream out, for max_pool_2x2.
// Handshake: in_valid qualifies in_sof/in_data and there is no ready; every valid pixel is consumed that cycle. out_valid is a one-cycle pulse with no backpressure.
interface max_pool_2x2_if #(
  parameter int DATA_W = 22
);
  logic                     in_valid;
  logic                     in_sof;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic                     out_last;
  logic signed [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_sof, in_data,
    input  out_valid, out_last, out_data
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output out_valid, out_last, out_data
  );
endinterface

// File: rtl/max_pool_2x2.sv
// 2x2 stride-2 signed max pooling over a raster-order pixel stream.
// Even rows fold pixel pairs into a half-width line buffer; odd rows finish each window.
module max_pool_2x2 #(
  parameter int DATA_W = 22,
  parameter int IMG_W  = 32,
  parameter int IMG_H  = 32
) (
  input  logic           clk,
  input  logic           rst,
  max_pool_2x2_if.slave  pool
);
  localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
  localparam int HW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]            r_col;
  logic [RW-1:0]            r_row;
  logic signed [DATA_W-1:0] r_h;
  logic signed [DATA_W-1:0] r_out_data;
  logic                     r_out_valid;
  logic                     r_out_last;
  logic signed [DATA_W-1:0] r_line [0:(1<<HW)-1];

  logic [CW-1:0]            w_col;
  logic [RW-1:0]            w_row;
  logic [HW-1:0]            w_half;
  logic signed [DATA_W-1:0] w_pair;
  logic signed [DATA_W-1:0] w_quad;

  function automatic logic signed [DATA_W-1:0] smax(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // A start-of-frame pixel is (0,0) whatever the counters say.
  always_comb begin
    w_col  = pool.in_sof ? '0 : r_col;
    w_row  = pool.in_sof ? '0 : r_row;
    w_half = HW'(w_col >> 1);
    w_pair = smax(r_h, pool.in_data);
    w_quad = smax(r_line[w_half], w_pair);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_h         <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      if (pool.in_valid) begin
        if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
        end else begin
          r_col <= w_col + 1'b1;
          r_row <= w_row;
        end
        if (!w_col[0]) begin
          r_h <= pool.in_data;
        end else if (w_row[0]) begin
          r_out_data  <= w_quad;
          r_out_valid <= 1'b1;
          r_out_last  <= (w_row == ROW_LAST) && (w_col == COL_LAST);
        end
      end
    end
  end

  // Every entry is written on an even row before the odd row reads it, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && pool.in_valid && w_col[0] && !w_row[0]) begin
      r_line[w_half] <= w_pair;
    end
  end

  assign pool.out_valid = r_out_valid;
  assign pool.out_last  = r_out_last;
  assign pool.out_data  = r_out_data;
endmodule

// File: tb/tb_max_pool_2x2.sv
// Bench for max_pool_2x2: directed frames plus random frames checked against a whole-image model.
module tb_max_pool_2x2;
  localparam int DATA_W = 22;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 2;
  localparam int SW     = 16 + 1 + DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   mr = 0;
  int   mc = 0;

  logic [SW-1:0]            exp_q[$];
  logic [SW-1:0]            obs_q[$];
  logic signed [DATA_W-1:0] img [0:IMG_H-1][0:IMG_W-1];

  max_pool_2x2_if #(.DATA_W(DATA_W)) pool ();

  max_pool_2x2 #(.DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk  (clk),
    .rst  (rst),
    .pool (pool)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor: each pulse stamped with the cycle it is seen in
  always @(negedge clk) begin
    if (pool.out_valid === 1'b1) obs_q.push_back({cyc[15:0], pool.out_last, pool.out_data});
  end

  function automatic logic signed [DATA_W-1:0] ref_max(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // driver: one accepted pixel; the model places it in the image and, when it
  // completes a window, expects that window's max one cycle later.
  task automatic send(input logic sof, input logic signed [DATA_W-1:0] d);
    logic signed [DATA_W-1:0] m;
    @(negedge clk);
    pool.in_valid = 1'b1;
    pool.in_sof   = sof;
    pool.in_data  = d;
    if (sof) begin mr = 0; mc = 0; end
    img[mr][mc] = d;
    if ((mr % 2 == 1) && (mc % 2 == 1)) begin
      m = ref_max(ref_max(img[mr-1][mc-1], img[mr-1][mc]), ref_max(img[mr][mc-1], img[mr][mc]));
      exp_q.push_back({16'(cyc + 1), (mr == IMG_H - 1) && (mc == IMG_W - 1), m});
    end
    mc++;
    if (mc == IMG_W) begin
      mc = 0;
      mr++;
      if (mr == IMG_H) mr = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      pool.in_valid = 1'b0;
      pool.in_sof   = $urandom_range(0, 1);
      pool.in_data  = DATA_W'($urandom);
    end
  endtask

  task automatic send_frame(input int v [8], input int gap_max);
    for (int i = 0; i < 8; i++) begin
      if (gap_max > 0) idle($urandom_range(1, gap_max));
      send(1'b0, DATA_W'(v[i]));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      pool.in_valid = 1'b1;
      pool.in_sof   = 1'b0;
      pool.in_data  = DATA_W'($urandom);
    end
    @(negedge clk);
    checks++; if (pool.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", pool.out_valid); end
    checks++; if (pool.out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b want 0", pool.out_last); end
    checks++; if (pool.out_data !== '0) begin errors++; $display("FAIL reset_data got %0d want 0", pool.out_data); end
    rst = 1'b0;
    pool.in_valid = 1'b0;
    mr = 0; mc = 0;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_basic();
    int v [8] = '{1, 5, 2, 3, 4, 0, 7, -1};
    send_frame(v, 0);
    idle(3);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL basic_count got %0d want 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0][DATA_W:0] !== {1'b0, 22'sd5}) begin errors++; $display("FAIL basic_first got %h want 5 last=0", obs_q[0][DATA_W:0]); end
      checks++; if (obs_q[1][DATA_W:0] !== {1'b1, 22'sd7}) begin errors++; $display("FAIL basic_second got %h want 7 last=1", obs_q[1][DATA_W:0]); end
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_negative();
    int v [8] = '{-8, -3, -9, -4, -5, -6, -2, -7};
    send_frame(v, 0);
    idle(3);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL neg_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    if (obs_q.size() == 2) begin
      checks++; if (obs_q[0][DATA_W-1:0] !== -22'sd3) begin errors++; $display("FAIL neg_first got %0d want -3", $signed(obs_q[0][DATA_W-1:0])); end
    end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL neg_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_gaps();
    int v [8] = '{1, 5, 2, 3, 4, 0, 7, -1};
    send_frame(v, 3);
    idle(4);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL gaps_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL gaps_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_sof_abort();
    for (int i = 0; i < 3; i++) send(1'b0, DATA_W'($urandom));
    send(1'b1, 22'sd9);
    for (int i = 1; i < 8; i++) send(1'b0, DATA_W'($urandom_range(0, 20)) - 22'sd10);
    idle(3);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL sof_count got %0d want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL sof_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int v [8] = '{1, 5, 2, 3, 4, 0, 7, -1};
    for (int i = 0; i < 5; i++) send(1'b0, DATA_W'($urandom));
    @(negedge clk);
    rst = 1'b1;
    pool.in_valid = 1'b1;
    pool.in_data  = 22'sd100;
    @(negedge clk);
    checks++; if (pool.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", pool.out_valid); end
    checks++; if (pool.out_data !== '0) begin errors++; $display("FAIL rstmid_data got %0d want 0", pool.out_data); end
    rst = 1'b0;
    pool.in_valid = 1'b0;
    mr = 0; mc = 0;
    send_frame(v, 0);
    idle(3);
    checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL rstmid_count got %0d want 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) send(1'b0, DATA_W'($urandom_range(0, 200)) - 22'sd100);
    idle(3);
    checks++; if (obs_q.size() !== 4) begin errors++; $display("FAIL b2b_count got %0d want 4", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  // random frames: full-range and tie-heavy data, random gaps, some frames cut short by sof
  task automatic test_random();
    logic signed [DATA_W-1:0] d;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < $urandom_range(1, 6); i++) send(1'b0, DATA_W'($urandom));
      end
      for (int i = 0; i < IMG_W * IMG_H; i++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        d = (f % 2 == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 3)) - 22'sd2;
        send((i == 0) && ($urandom_range(0, 1) == 1 || mc != 0 || mr != 0), d);
      end
    end
    idle(3);
    checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_out[%0d] got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    pool.in_valid = 1'b0;
    pool.in_sof   = 1'b0;
    pool.in_data  = '0;
    test_reset();
    test_basic();
    test_negative();
    test_gaps();
    test_sof_abort();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/max_pool_2x2.md
MAX_POOL_2X2 -- requirements
Module: max_pool_2x2

Interface
REQ-001 SHALL have parameter DATA_W, default 22, meaning sample width (signed), matching the normalise/ReLU output width.
REQ-002 SHALL have parameter IMG_W, default 32, meaning pixels per row (even, >=2).
REQ-003 SHALL have parameter IMG_H, default 32, meaning rows per frame (even, >=2).
REQ-004 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port in_valid  input  1  in_data carries a pixel this cycle.
REQ-007 SHALL have port in_sof  input  1  the pixel qualified by in_valid is pixel (row 0, col 0) of a frame.
REQ-008 SHALL have port in_data  input  DATA_W  signed pixel, raster order (row-major).
REQ-009 SHALL have port out_valid  output  1  out_data is a pooled result, one-cycle pulse.
REQ-010 SHALL have port out_data  output  DATA_W  signed max of one 2x2 window.
REQ-011 SHALL have port out_last  output  1  high with out_valid on the final window of a frame.

Function
REQ-012 SHALL keep column counter col (0..IMG_W-1) and row counter row (0..IMG_H-1), advancing only on cycles with in_valid=1.
REQ-013 SHALL, on an accepted pixel, increment col; at col=IMG_W-1 wrap col to 0 and increment row; at row=IMG_H-1 and col=IMG_W-1 wrap both to 0.
REQ-014 SHALL treat a pixel with in_valid=1 and in_sof=1 as (0,0) regardless of counter state, discarding any partial window; next pixel is (0,1).
REQ-015 SHALL hold all counters, registers and outputs other than out_valid/out_last when in_valid=0; no pixel is dropped or duplicated by gaps.
REQ-016 SHALL, on even col, capture in_data into horizontal register h_reg.
REQ-017 SHALL, on odd col of an even row, write signed max(h_reg, in_data) to line buffer entry col/2 (IMG_W/2 entries x DATA_W).
REQ-018 SHALL, on odd col of an odd row, register out_data = signed max(line_buf[col/2], h_reg, in_data) and assert out_valid the next cycle (latency 1 cycle from the bottom-right pixel).
REQ-019 SHALL use signed two's-complement comparison; ties yield the equal value; no width change or saturation.
REQ-020 SHALL assert out_last together with out_valid exactly when the window's bottom-right pixel is (IMG_H-1, IMG_W-1).
REQ-021 SHALL deassert out_valid and out_last in every cycle not specified by REQ-018/REQ-020; out_data holds its last value otherwise.
REQ-022 SHALL produce exactly (IMG_W/2)*(IMG_H/2) out_valid pulses per uninterrupted frame.
REQ-023 SHALL accept back-to-back frames with no idle cycle; the first pixel after a wrap is (0,0) with or without in_sof.

Reset
REQ-024 SHALL, while rst=1 at a clock edge, set col=0, row=0, h_reg=0, out_valid=0, out_last=0, out_data=0; in_valid is ignored in that cycle.
REQ-025 SHALL NOT require line buffer reset; every entry is written on an even row before it is read.
REQ-026 SHALL, on rst mid-frame, abandon the partial frame; the first accepted pixel after rst deasserts is (0,0).

Verification
REQ-027 IMG_W=4, IMG_H=2, continuous in_valid, pixels 1,5,2,3 / 4,0,7,-1 -> out_valid pulses with out_data 5 then 7; second pulse has out_last=1; each 1 cycle after pixels 6 and 8.
REQ-028 Same frame, all pixels negative (-8,-3,-9,-4 / -5,-6,-2,-7) -> out_data -3 then -2 (signed compare).
REQ-029 Same frame with in_valid=0 gaps of 1-3 cycles between every pixel -> identical outputs, out_valid only 1 cycle after pixels 6 and 8.
REQ-030 Send 3 pixels, then in_sof=1 with a fresh full frame -> only the fresh frame's 2 windows appear, correct values, out_last on the second.
REQ-031 Assert rst for 1 cycle after pixel 5 of a frame, then send a full frame -> no output from the aborted frame; outputs match REQ-027; out_valid=0, out_data=0 immediately after reset.
REQ-032 Two back-to-back frames, no in_sof, no gaps -> 4 pulses, out_last on 2nd and 4th, values from each frame's own pixels.
